// File: rtl/bcd_to_dec_hold_pkg.sv
// bcd_to_dec_hold shared package: FSM states and decode widths.
// Optional error counter is enabled by the macro BCD_ERR_CNT_EN.
package bcd_to_dec_hold_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEC_W   = 10;
    localparam int BCD_MAX = 9;
    localparam int HCNT_W  = 8;

endpackage

// File: rtl/bcd_to_dec_hold_if.sv
// Digit-in / one-hot-out bundle for bcd_to_dec_hold.
// err_count is present only when BCD_ERR_CNT_EN is defined.
interface bcd_to_dec_hold_if
    import bcd_to_dec_hold_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic [3:0]       bcd_in;
    logic             in_valid;
    logic             in_ready;
    logic [DEC_W-1:0] dec_out;
    logic             out_valid;
    logic             err;
`ifdef BCD_ERR_CNT_EN
    logic [CNT_W-1:0] err_count;

    modport master (
        output bcd_in, in_valid,
        input  in_ready, dec_out, out_valid, err, err_count
    );

    modport slave (
        input  bcd_in, in_valid,
        output in_ready, dec_out, out_valid, err, err_count
    );
`else
    modport master (
        output bcd_in, in_valid,
        input  in_ready, dec_out, out_valid, err
    );

    modport slave (
        input  bcd_in, in_valid,
        output in_ready, dec_out, out_valid, err
    );
`endif

endinterface

// File: rtl/bcd_onehot_dec.sv
// Combinational 4-to-10 one-hot decode with a non-decimal flag.
// Codes 10..15 give an all-zero line and raise invalid.
module bcd_onehot_dec
    import bcd_to_dec_hold_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [DEC_W-1:0] onehot,
    output logic             invalid
);

    // Decode; a non-decimal code never lights any line.
    always_comb begin
        invalid = (bcd > 4'(BCD_MAX));
        onehot  = '0;
        if (!invalid) begin
            onehot = DEC_W'(1) << bcd;
        end
    end

endmodule

// File: rtl/bcd_to_dec_hold.sv
// BCD digit decoder that holds each one-hot line for HOLD_CYCLES.
// Define BCD_ERR_CNT_EN to add the saturating err_count output.
module bcd_to_dec_hold
    import bcd_to_dec_hold_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_dec_hold_if.slave bus
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    localparam logic [HCNT_W-1:0] RELOAD = HCNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [HCNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DEC_W-1:0]   dec_q, dec_d;
    logic               err_q, err_d;
    logic [DEC_W-1:0]   dec_w;
    logic               inv_w;
    logic               accept;

    bcd_onehot_dec u_dec (
        .bcd     (bus.bcd_in),
        .onehot  (dec_w),
        .invalid (inv_w)
    );

    // Ready depends only on held state, never on in_valid.
    assign bus.in_ready  = (state_q == IDLE) || (hold_cnt_q == '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.dec_out   = dec_q;
    assign bus.err       = err_q;
    assign bus.out_valid = (state_q == HOLD);

    // Next state: load on accept, count down while held, release at zero.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        dec_d      = dec_q;
        err_d      = err_q;
        if (accept) begin
            state_d    = HOLD;
            hold_cnt_d = RELOAD;
            dec_d      = dec_w;
            err_d      = inv_w;
        end else if (state_q == HOLD) begin
            if (hold_cnt_q == '0) begin
                state_d = IDLE;
                dec_d   = '0;
                err_d   = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end
    end

    // State, counter and held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            dec_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dec_q      <= dec_d;
            err_q      <= err_d;
        end
    end

`ifdef BCD_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Count accepted non-decimal digits, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && inv_w && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_bcd_to_dec_hold.sv
// Self-checking bench: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// against a cycles-remaining reference model.
module tb_bcd_to_dec_hold;

    localparam int H4 = 4;
    localparam int H1 = 1;
    localparam int EC4_MAX = 255;
    localparam int EC1_MAX = 3;

    logic clk = 1'b0;
    logic rst4, rst1;

    always #5 clk = ~clk;

    bcd_to_dec_hold_if #(.CNT_W(8)) a4 ();
    bcd_to_dec_hold_if #(.CNT_W(2)) a1 ();

    bcd_to_dec_hold #(.HOLD_CYCLES(H4), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (a4.slave)
    );

    bcd_to_dec_hold #(.HOLD_CYCLES(H1), .CNT_W(2)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (a1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m4_left = 0, m4_dig = 0, m4_ec = 0;
    int m1_left = 0, m1_dig = 0, m1_ec = 0;

    function automatic logic [9:0] exp_dec(int left, int dig);
        if (left == 0 || dig > 9) return 10'd0;
        return 10'(1 << dig);
    endfunction

    function automatic logic exp_err(int left, int dig);
        return (left > 0) && (dig > 9);
    endfunction

    task automatic tick(input logic v4, input int b4, input logic r4,
                        input logic v1, input int b1, input logic r1);
        a4.in_valid = v4;
        a4.bcd_in   = 4'(b4);
        rst4        = r4;
        a1.in_valid = v1;
        a1.bcd_in   = 4'(b1);
        rst1        = r1;
        @(posedge clk);
        if (r4) begin
            m4_left = 0; m4_ec = 0;
        end else if (v4 && m4_left <= 1) begin
            m4_left = H4; m4_dig = b4;
            if (b4 > 9 && m4_ec < EC4_MAX) m4_ec++;
        end else if (m4_left > 0) begin
            m4_left--;
        end
        if (r1) begin
            m1_left = 0; m1_ec = 0;
        end else if (v1 && m1_left <= 1) begin
            m1_left = H1; m1_dig = b1;
            if (b1 > 9 && m1_ec < EC1_MAX) m1_ec++;
        end else if (m1_left > 0) begin
            m1_left--;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 3, 1'b1, 1'b1, 3, 1'b1);
        n_checks++;
        if (a4.dec_out !== 10'd0) begin
            n_fail++; $display("FAIL rst_dec4 got %b exp 0", a4.dec_out);
        end
        n_checks++;
        if (a4.out_valid !== 1'b0 || a4.err !== 1'b0) begin
            n_fail++; $display("FAIL rst_ov_err4 got %b%b exp 00", a4.out_valid, a4.err);
        end
        n_checks++;
        if (a4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_ready4 got %b exp 1", a4.in_ready);
        end
        n_checks++;
        if (a1.dec_out !== 10'd0 || a1.out_valid !== 1'b0 || a1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_dut1 got dec=%b ov=%b rdy=%b exp 0/0/1",
                     a1.dec_out, a1.out_valid, a1.in_ready);
        end
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_digits();
        for (int d = 0; d < 10; d++) begin
            tick(1'b1, d, 1'b0, 1'b0, 0, 1'b0);
            for (int c = 0; c < H4; c++) begin
                if (c > 0) tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
                n_checks++;
                if (a4.dec_out !== 10'(1 << d) || a4.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL digit_dec d=%0d c=%0d got %b err=%b exp %b err=0",
                             d, c, a4.dec_out, a4.err, 10'(1 << d));
                end
                n_checks++;
                if (a4.out_valid !== 1'b1 || a4.in_ready !== (c == H4 - 1)) begin
                    n_fail++;
                    $display("FAIL digit_hold d=%0d c=%0d got ov=%b rdy=%b exp ov=1 rdy=%b",
                             d, c, a4.out_valid, a4.in_ready, (c == H4 - 1));
                end
            end
            tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
            n_checks++;
            if (a4.out_valid !== 1'b0 || a4.dec_out !== 10'd0) begin
                n_fail++;
                $display("FAIL digit_release d=%0d got ov=%b dec=%b exp 0",
                         d, a4.out_valid, a4.dec_out);
            end
        end
    endtask

    task automatic test_invalid();
        int codes[2] = '{10, 15};
        foreach (codes[i]) begin
            tick(1'b1, codes[i], 1'b0, 1'b0, 0, 1'b0);
            for (int c = 0; c < H4; c++) begin
                if (c > 0) tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
                n_checks++;
                if (a4.dec_out !== 10'd0 || a4.err !== 1'b1 || a4.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL invalid code=%0d c=%0d got dec=%b err=%b ov=%b exp 0/1/1",
                             codes[i], c, a4.dec_out, a4.err, a4.out_valid);
                end
            end
            tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
            n_checks++;
            if (a4.err !== 1'b0 || a4.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_release got err=%b ov=%b exp 0/0", a4.err, a4.out_valid);
            end
        end
`ifdef BCD_ERR_CNT_EN
        n_checks++;
        if (a4.err_count !== 8'd2) begin
            n_fail++; $display("FAIL err_count4 got %0d exp 2", a4.err_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        tick(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        for (int c = 0; c < H4; c++) begin
            n_checks++;
            if (a4.dec_out !== 10'b0000001000 || a4.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first c=%0d got dec=%b ov=%b exp 0000001000/1",
                         c, a4.dec_out, a4.out_valid);
            end
            tick(1'b1, 7, 1'b0, 1'b0, 0, 1'b0);
        end
        for (int c = 0; c < H4; c++) begin
            if (a4.out_valid !== 1'b1) gap++;
            n_checks++;
            if (a4.dec_out !== 10'b0010000000) begin
                n_fail++;
                $display("FAIL b2b_second c=%0d got %b exp 0010000000", c, a4.dec_out);
            end
            tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        end
        n_checks++;
        if (gap != 0) begin
            n_fail++; $display("FAIL b2b_gap got %0d idle cycles exp 0", gap);
        end
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 5, 1'b0, 1'b0, 0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (a4.dec_out !== 10'b0000100000 || a4.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre got dec=%b rdy=%b exp 0000100000/0", a4.dec_out, a4.in_ready);
        end
        tick(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
        n_checks++;
        if (a4.dec_out !== 10'd0 || a4.out_valid !== 1'b0 ||
            a4.err !== 1'b0 || a4.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst got dec=%b ov=%b err=%b rdy=%b exp 0/0/0/1",
                     a4.dec_out, a4.out_valid, a4.err, a4.in_ready);
        end
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (a4.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_drop got ov=%b exp 0", a4.out_valid);
        end
    endtask

    task automatic test_hold1();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 0, 1'b0, 1'b1, i, 1'b0);
            n_checks++;
            if (a1.dec_out !== 10'(1 << i) || a1.out_valid !== 1'b1 ||
                a1.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL hold1 i=%0d got dec=%b ov=%b rdy=%b exp %b/1/1",
                         i, a1.dec_out, a1.out_valid, a1.in_ready, 10'(1 << i));
            end
        end
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (a1.out_valid !== 1'b0 || a1.dec_out !== 10'd0) begin
            n_fail++;
            $display("FAIL hold1_release got ov=%b dec=%b exp 0", a1.out_valid, a1.dec_out);
        end
    endtask

`ifdef BCD_ERR_CNT_EN
    task automatic test_err_sat();
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 0, 1'b0, 1'b1, 10 + k, 1'b0);
            n_checks++;
            if (a1.err_count !== 2'(exp_cnt[k])) begin
                n_fail++;
                $display("FAIL err_sat k=%0d got %0d exp %0d", k, a1.err_count, exp_cnt[k]);
            end
        end
        tick(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 9) < 6), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 3));
            n_checks++;
            if (a4.dec_out !== exp_dec(m4_left, m4_dig) || a4.err !== exp_err(m4_left, m4_dig) ||
                a4.out_valid !== (m4_left > 0) || a4.in_ready !== (m4_left <= 1)) begin
                n_fail++;
                $display("FAIL rand4 n=%0d got dec=%b err=%b ov=%b rdy=%b exp %b/%b/%b/%b",
                         n, a4.dec_out, a4.err, a4.out_valid, a4.in_ready,
                         exp_dec(m4_left, m4_dig), exp_err(m4_left, m4_dig),
                         (m4_left > 0), (m4_left <= 1));
            end
            n_checks++;
            if (a1.dec_out !== exp_dec(m1_left, m1_dig) || a1.err !== exp_err(m1_left, m1_dig) ||
                a1.out_valid !== (m1_left > 0) || a1.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand1 n=%0d got dec=%b err=%b ov=%b rdy=%b exp %b/%b/%b/1",
                         n, a1.dec_out, a1.err, a1.out_valid, a1.in_ready,
                         exp_dec(m1_left, m1_dig), exp_err(m1_left, m1_dig), (m1_left > 0));
            end
`ifdef BCD_ERR_CNT_EN
            n_checks++;
            if (a4.err_count !== 8'(m4_ec) || a1.err_count !== 2'(m1_ec)) begin
                n_fail++;
                $display("FAIL rand_errcnt n=%0d got %0d/%0d exp %0d/%0d",
                         n, a4.err_count, a1.err_count, m4_ec, m1_ec);
            end
`endif
        end
    endtask

    initial begin
        a4.in_valid = 1'b0;
        a4.bcd_in   = 4'd0;
        a1.in_valid = 1'b0;
        a1.bcd_in   = 4'd0;
        rst4        = 1'b1;
        rst1        = 1'b1;
        test_reset();
        test_digits();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_hold1();
`ifdef BCD_ERR_CNT_EN
        test_err_sat();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_dec_hold.md
# bcd_to_dec_hold

Sequential BCD-to-decimal decoder. Accepts one 4-bit BCD digit per valid/ready transfer and drives the matching one-hot 10-bit decimal line. The line is held for a programmable number of cycles, and non-decimal codes (10–15) are flagged. It sits downstream of the decimal-to-BCD encoder path and drives LED/indicator logic that needs a stable one-hot line.

## Interface
Parameters:
- HOLD_CYCLES, 4, cycles each decoded digit stays on `dec_out`; legal range 1..255.
- CNT_W, 8, width of the error counter (used only when `BCD_ERR_CNT_EN` is defined).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- bcd_in  input  4  BCD digit; sampled on accept.
- in_valid  input  1  `bcd_in` is valid.
- in_ready  output  1  block can accept a digit this cycle.
- dec_out  output  10  one-hot decimal; bit n set for digit n.
- out_valid  output  1  `dec_out`/`err` hold a decoded digit.
- err  output  1  the held digit was 10..15.
- err_count  output  CNT_W  saturating count of invalid digits (present only with `BCD_ERR_CNT_EN`).

## Operation
FSM states:
- IDLE: no digit is held. `out_valid`=0, `dec_out`=0, `err`=0, `in_ready`=1.
- HOLD: a digit is held. `out_valid`=1 and `hold_cnt` counts down from HOLD_CYCLES-1 to 0. `in_ready`=1 only when `hold_cnt`==0.

Accept and decode:
- Accept = `in_valid` && `in_ready`.
- On accept, at the next edge:
  - `dec_out` = 10'b1 << `bcd_in` if `bcd_in` ≤ 9, else 10'b0.
  - `err` = (`bcd_in` > 9).
  - state = HOLD; `hold_cnt` = HOLD_CYCLES-1.

Transitions:
- HOLD with `hold_cnt`==0 and no accept → IDLE next edge; `dec_out`, `err` and `out_valid` are cleared.
- HOLD with `hold_cnt`==0 and accept (simultaneous release and new digit) → stay in HOLD, load the new digit, reload `hold_cnt`, no idle gap. `out_valid` stays 1.
- `in_valid` while `in_ready`=0 is ignored. The source must keep `bcd_in` stable until accepted.
- `dec_out` is always one-hot or zero; never more than one bit set.

Reset:
- `rst` at any point, including mid-HOLD, forces at the next edge: state IDLE, `hold_cnt`=0, `dec_out`=0, `err`=0, `out_valid`=0, `err_count`=0.
- `in_ready`=1 the cycle after reset is released.
- A digit presented in the same cycle as `rst` is dropped.

## Timing
- Latency: accept at edge k → `dec_out`/`out_valid` valid after edge k (visible in cycle k+1).
- Hold: `out_valid` stays high for exactly HOLD_CYCLES cycles per digit.
- Throughput: back-to-back accepts spaced HOLD_CYCLES cycles apart. With HOLD_CYCLES=1, one digit per cycle and `in_ready` stays 1.
- `in_ready` is combinational from state and `hold_cnt` only. It has no path from `in_valid`.
- All other outputs are registered.

## Configuration
- `BCD_ERR_CNT_EN` defined:
  - `err_count` port exists.
  - It increments by 1 on each accepted digit > 9 and saturates at 2^CNT_W-1 (no wrap).
  - It is cleared by `rst`.
- Not defined: the port and counter are absent. `err` behaviour is unchanged.

## Structure
- Shared package holds:
  - the FSM state constants IDLE=1'b0 and HOLD=1'b1;
  - the constant DEC_W=10;
  - the constant BCD_MAX=9.
- One sub-module, `bcd_onehot_dec`: purely combinational 4→10 one-hot decode plus invalid flag. The top level registers its output.
- The top level contains the FSM, `hold_cnt` and the optional error counter.

## Test plan
1. Reset, then each `bcd_in` 0..9 with HOLD_CYCLES=4 → `dec_out` = 10'b0000000001 … 10'b1000000000, `err`=0. `out_valid` high exactly 4 cycles each; `in_ready` low for the first 3.
2. `bcd_in`=4'hA, then 4'hF → `dec_out`=0, `err`=1, `out_valid`=1 for 4 cycles. With the macro, `err_count` reads 2.
3. `in_valid` held high, HOLD_CYCLES=4, digits 3 then 7 → `dec_out` shows 10'b0000001000 for 4 cycles, then 10'b0010000000 with no cycle of `out_valid`=0.
4. `rst` asserted in the 2nd HOLD cycle of digit 5 → next cycle `dec_out`=0, `out_valid`=0, `err`=0, `in_ready`=1.
5. HOLD_CYCLES=1, stream 0,1,2,…,9 → one new one-hot value per cycle; `in_ready` constantly 1.
6. With the macro and CNT_W=2, five invalid digits → `err_count` = 1, 2, 3, 3, 3 (saturates).
